fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
// Parametrised forwarding + load-use hazard unit for the pipelined core. Tracks in-flight
// register writes in an internal DEPTH-stage tag scoreboard (EX/MEM, MEM/WB, ...). Decides
// in ID whether each source operand needs a bypass and from which stage, and registers that
// select into EX. Raises a stall when a multi-cycle producer (load) cannot be bypassed in time.
// PARAMETERS
// NUM_SRC   2   source operands per instruction
// DEPTH     2   bypassable stages after EX (stage 1 = EX/MEM, stage 2 = MEM/WB, ...)
// RA_W      5   register address width; register 0 is hard-wired zero, never forwarded
// LOAD_LAT  1   extra stages before load data is forwardable (load ready at stage 1+LOAD_LAT)
// CNT_W     32  stall performance counter width
// SEL_W     $clog2(DEPTH+1), derived localparam, not overridable
// PORTS
// clk          in   1              clock; all state updates on rising edge
// reset        in   1              synchronous, active-high
// id_valid     in   1              ID stage holds a valid instruction
// id_rs        in   NUM_SRC*RA_W   ID source addrs; operand i at [i*RA_W +: RA_W]
// id_rs_used   in   NUM_SRC        operand i is actually read
// ex_valid     in   1              EX stage holds a valid instruction
// ex_rd        in   RA_W           EX destination register
// ex_reg_write in   1              EX instruction writes rd
// ex_mem_read  in   1              EX instruction is a load
// flush        in   1              kill the ID instruction (branch redirect)
// stall        out  1              hold PC and IF/ID, inject bubble into ID/EX (combinational)
// fwd_sel      out  NUM_SRC*SEL_W  registered, for operand in EX: 0 = regfile, k = stage k
// hazard_err   out  1              sticky: EX consumed an operand whose producer was not ready
// stall_count  out  CNT_W          saturating count of cycles with stall=1
// BEHAVIOUR
// - Reset: all scoreboard valid bits 0, fwd_sel 0, hazard_err 0, stall_count 0.
// - Scoreboard entry: {valid, rd, ready_stage}; ready_stage = 1+LOAD_LAT for loads, else 1.
//   Every cycle (stall or not) stage[k+1] <= stage[k]; stage[1] <= EX instr, valid only if
//   ex_valid & ex_reg_write & ex_rd!=0. Stage DEPTH retires. Tail never stalls.
// - Producer position p: EX = 0, stage k = k. Per used operand i with id_rs[i]!=0, choose the
//   NEAREST producer (smallest p) with matching rd; older matches are shadowed.
// - Stall: any used operand whose nearest producer has p+1 < ready_stage, and p+1 <= DEPTH.
//   Nearest producer with p+1 > DEPTH (retiring) -> regfile, no stall. stall = id_valid &
//   ~flush & (any operand hazard). Combinational, same cycle.
// - Next fwd_sel[i]: p+1 of nearest producer, else 0. Registered at clock edge. If stall,
//   flush or ~id_valid, all fwd_sel <= 0 (bubble enters EX).
// - Repeated stall: ID holds; next cycle producer has advanced, re-evaluate; load with
//   LOAD_LAT=L stalls exactly L cycles when consumer immediately follows it.
// - hazard_err: set when a registered fwd_sel=k points at a stage whose entry has
//   ready_stage > k or rd mismatch; cleared only by reset. Verification aid, never expected.
// - stall_count: +1 each cycle stall=1; holds at 2^CNT_W-1.
// - Reset mid-stall: next cycle stall=0 (scoreboard empty), fwd_sel 0, counter 0.
// - Simultaneous flush and hazard: flush wins, stall=0, scoreboard still shifts EX in.
// TESTING
// ALU x5 in EX, next ID reads rs1=x5 -> stall=0; next cycle fwd_sel[0]=1, fwd_sel[1]=0.
// Load x7 in EX, ID reads rs2=x7 (LOAD_LAT=1) -> stall=1 one cycle, then fwd_sel[1]=2.
// x3 written by EX-stage ALU and stage-1 load; ID reads x3 -> nearest (EX) wins, sel=1, no stall.
// ID reads x0 with ALU rd=x0 in EX -> stall=0, fwd_sel=0; also id_rs_used=0 -> sel=0.
// Load x9 in EX, ID reads x9, flush=1 same cycle -> stall=0, fwd_sel<=0, stall_count unchanged.
// CNT_W=4, force 20 stall cycles -> stall_count=15; assert reset -> all outputs 0 next edge.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding select and load-use stall for the pipelined core.
//
// A DEPTH-stage tag scoreboard follows every register write leaving EX. In ID, each used
// source operand looks for its nearest in-flight producer (EX first, then stage 1..DEPTH).
// It then chooses which stage it will read in EX, or stalls if that producer's data is
// not ready in time.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   id_valid        ID holds a valid instruction
//   id_rs           NUM_SRC source addresses, operand i at [i*RA_W +: RA_W]
//   id_rs_used      per-operand "actually read" flags
//   ex_valid        EX holds a valid instruction
//   ex_rd           EX destination register
//   ex_reg_write    EX instruction writes ex_rd
//   ex_mem_read     EX instruction is a load
//   flush           kill the ID instruction
//   stall           combinational: hold PC and IF/ID, bubble into ID/EX
//   fwd_sel         registered per-operand select for EX: 0 = regfile, k = stage k
//   hazard_err      sticky: EX read a stage that did not hold the right, ready value
//   stall_count     saturating count of stall cycles

// Per-operand producer search over candidates 0 (EX) .. DEPTH (oldest stage).
module fwd_src_sel #(
    parameter int DEPTH = 2,
    parameter int RA_W  = 5,
    parameter int RS_W  = 2,
    parameter int SEL_W = 2
) (
    input  logic [RA_W-1:0]             rs,
    input  logic                        used,
    input  logic [DEPTH:0]              cand_vld,
    input  logic [DEPTH:0][RA_W-1:0]    cand_rd,
    input  logic [DEPTH:0][RS_W-1:0]    cand_rs,
    output logic [SEL_W-1:0]            sel,
    output logic                        haz
);
    logic found;

    always_comb begin
        sel   = '0;
        haz   = 1'b0;
        found = 1'b0;
        if (used && rs != '0) begin
            for (int p = 0; p <= DEPTH; p++) begin
                if (!found && cand_vld[p] && cand_rd[p] == rs) begin
                    found = 1'b1;
                    // A producer at p is read from stage p+1 in EX. If that lies past
                    // the scoreboard, the value is already in the regfile, so keep sel=0.
                    if (p + 1 <= DEPTH) begin
                        sel = SEL_W'(p + 1);
                        haz = (p + 1) < int'(cand_rs[p]);
                    end
                end
            end
        end
    end
endmodule

module fwd_hazard_unit #(
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 2,
    parameter int RA_W     = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              id_valid,
    input  logic [NUM_SRC*RA_W-1:0]           id_rs,
    input  logic [NUM_SRC-1:0]                id_rs_used,
    input  logic                              ex_valid,
    input  logic [RA_W-1:0]                   ex_rd,
    input  logic                              ex_reg_write,
    input  logic                              ex_mem_read,
    input  logic                              flush,
    output logic                              stall,
    output logic [NUM_SRC*$clog2(DEPTH+1)-1:0] fwd_sel,
    output logic                              hazard_err,
    output logic [CNT_W-1:0]                  stall_count
);
    localparam int SEL_W = $clog2(DEPTH + 1);
    localparam int RS_W  = $clog2(LOAD_LAT + 2) + 1;

    // Scoreboard: stage k holds the write that left EX k cycles ago.
    logic [DEPTH:1]             sb_vld;
    logic [DEPTH:1][RA_W-1:0]   sb_rd;
    logic [DEPTH:1][RS_W-1:0]   sb_rs;

    logic                       ex_wr;
    logic [RS_W-1:0]            ex_ready;
    logic [DEPTH:0]             cand_vld;
    logic [DEPTH:0][RA_W-1:0]   cand_rd;
    logic [DEPTH:0][RS_W-1:0]   cand_rs;

    logic [NUM_SRC-1:0][RA_W-1:0]  rs_vec;
    logic [NUM_SRC-1:0][SEL_W-1:0] sel_nxt;
    logic [NUM_SRC-1:0]            haz_vec;
    logic [NUM_SRC-1:0][SEL_W-1:0] fwd_sel_q;
    logic [NUM_SRC-1:0][RA_W-1:0]  ex_rs_q;
    logic [NUM_SRC-1:0]            bad_vec;
    logic                          kill;

    assign ex_wr    = ex_valid & ex_reg_write & (ex_rd != '0);
    assign ex_ready = ex_mem_read ? RS_W'(1 + LOAD_LAT) : RS_W'(1);
    // Candidate 0 is the live EX instruction, candidates 1..DEPTH are the scoreboard.
    assign cand_vld = {sb_vld, ex_wr};
    assign cand_rd  = {sb_rd, ex_rd};
    assign cand_rs  = {sb_rs, ex_ready};
    assign rs_vec   = id_rs;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_sel #(.DEPTH(DEPTH), .RA_W(RA_W), .RS_W(RS_W), .SEL_W(SEL_W)) u_sel (
            .rs       (rs_vec[i]),
            .used     (id_rs_used[i]),
            .cand_vld (cand_vld),
            .cand_rd  (cand_rd),
            .cand_rs  (cand_rs),
            .sel      (sel_nxt[i]),
            .haz      (haz_vec[i])
        );

        // The operand now in EX reads stage fwd_sel_q; that stage must hold its register,
        // with data already available.
        always_comb begin
            bad_vec[i] = 1'b0;
            for (int k = 1; k <= DEPTH; k++) begin
                if (fwd_sel_q[i] == SEL_W'(k))
                    bad_vec[i] = !sb_vld[k] || sb_rd[k] != ex_rs_q[i] || int'(sb_rs[k]) > k;
            end
        end
    end

    // Flush wins over a hazard: the ID instruction is dead, so there is nothing to hold.
    assign stall   = id_valid & ~flush & (|haz_vec);
    assign kill    = stall | flush | ~id_valid;
    assign fwd_sel = fwd_sel_q;

    // The tail never stalls: the scoreboard shifts every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_vld <= '0;
            sb_rd  <= '0;
            sb_rs  <= '0;
        end else begin
            sb_vld[1] <= ex_wr;
            sb_rd[1]  <= ex_rd;
            sb_rs[1]  <= ex_ready;
            for (int k = 2; k <= DEPTH; k++) begin
                sb_vld[k] <= sb_vld[k-1];
                sb_rd[k]  <= sb_rd[k-1];
                sb_rs[k]  <= sb_rs[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_sel_q   <= '0;
            ex_rs_q     <= '0;
            hazard_err  <= 1'b0;
            stall_count <= '0;
        end else begin
            fwd_sel_q <= kill ? '0 : sel_nxt;
            ex_rs_q   <= rs_vec;
            if (|bad_vec)
                hazard_err <= 1'b1;
            if (stall && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;
    localparam int NS = 2, D = 2, RW = 5, L = 1, CW = 4, SW = 2;

    logic              clk = 0, reset;
    logic              id_valid, ex_valid, ex_reg_write, ex_mem_read, flush;
    logic [NS*RW-1:0]  id_rs;
    logic [NS-1:0]     id_rs_used;
    logic [RW-1:0]     ex_rd;
    logic              stall, hazard_err;
    logic [NS*SW-1:0]  fwd_sel;
    logic [CW-1:0]     stall_count;

    int checks = 0, failures = 0;

    fwd_hazard_unit #(.NUM_SRC(NS), .DEPTH(D), .RA_W(RW), .LOAD_LAT(L), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .flush(flush), .stall(stall), .fwd_sel(fwd_sel),
        .hazard_err(hazard_err), .stall_count(stall_count));

    always #5 clk = ~clk;

    // Model: history of the writes that left EX, indexed by age in cycles.
    logic          h_w  [1:D];
    logic [RW-1:0] h_rd [1:D];
    logic          h_ld [1:D];
    logic [NS*SW-1:0] exp_sel;
    int               exp_cnt;

    function automatic void model(output logic st, output logic [NS*SW-1:0] s);
        logic any = 0;
        s = '0;
        for (int i = 0; i < NS; i++) begin
            logic [RW-1:0] r = id_rs[i*RW +: RW];
            bit done = 0;
            if (id_rs_used[i] && r != 0) begin
                for (int age = 0; age <= D; age++) begin
                    logic w; logic [RW-1:0] rd; logic ld;
                    if (age == 0) begin
                        w = ex_valid && ex_reg_write && ex_rd != 0; rd = ex_rd; ld = ex_mem_read;
                    end else begin
                        w = h_w[age]; rd = h_rd[age]; ld = h_ld[age];
                    end
                    if (!done && w && rd == r) begin
                        done = 1;
                        // The value is needed one cycle later, in EX, when the producer is age+1 old.
                        if (age < D) begin
                            s[i*SW +: SW] = SW'(age + 1);
                            if (age + 1 < (ld ? 1 + L : 1)) any = 1;
                        end
                    end
                end
            end
        end
        st = id_valid && !flush && any;
        if (st || flush || !id_valid) s = '0;
    endfunction

    always @(posedge clk) begin
        logic st; logic [NS*SW-1:0] s;
        if (reset) begin
            for (int k = 1; k <= D; k++) begin h_w[k] = 0; h_rd[k] = 0; h_ld[k] = 0; end
            exp_sel = '0; exp_cnt = 0;
        end else begin
            model(st, s);
            exp_sel = s;
            if (st && exp_cnt < (1 << CW) - 1) exp_cnt++;
            for (int k = D; k > 1; k--) begin h_w[k] = h_w[k-1]; h_rd[k] = h_rd[k-1]; h_ld[k] = h_ld[k-1]; end
            h_w[1] = ex_valid && ex_reg_write && ex_rd != 0; h_rd[1] = ex_rd; h_ld[1] = ex_mem_read;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model compare on every cycle out of reset.
    always @(negedge clk) begin
        logic st; logic [NS*SW-1:0] s;
        if (!reset) begin
            model(st, s);
            check("cmp_stall", int'(stall), int'(st));
            check("cmp_fwd_sel", int'(fwd_sel), int'(exp_sel));
            check("cmp_stall_count", int'(stall_count), exp_cnt);
            check("cmp_hazard_err", int'(hazard_err), 0);
        end
    end

    task automatic idle();
        id_valid = 0; id_rs = '0; id_rs_used = '0; flush = 0;
        ex_valid = 0; ex_rd = '0; ex_reg_write = 0; ex_mem_read = 0;
    endtask
    task automatic ex_set(input logic [RW-1:0] rd, input logic ld);
        ex_valid = 1; ex_rd = rd; ex_reg_write = 1; ex_mem_read = ld;
    endtask
    task automatic ex_off(); ex_valid = 0; ex_reg_write = 0; ex_mem_read = 0; ex_rd = '0; endtask
    task automatic id_set(input logic [RW-1:0] r0, input logic [RW-1:0] r1, input logic [1:0] u);
        id_valid = 1; id_rs = {r1, r0}; id_rs_used = u;
    endtask
    task automatic step(); @(posedge clk); #1; endtask

    initial begin
        reset = 1; idle();
        step(); step();
        @(negedge clk);
        check("reset_fwd_sel", int'(fwd_sel), 0);
        check("reset_count", int'(stall_count), 0);
        check("reset_err", int'(hazard_err), 0);
        check("reset_stall", int'(stall), 0);
        step(); reset = 0;

        // ALU x5 in EX, ID reads rs1=x5
        ex_set(5, 0); id_set(5, 0, 2'b01);
        @(negedge clk); check("alu_no_stall", int'(stall), 0);
        step(); idle();
        @(negedge clk); check("alu_sel", int'(fwd_sel), 4'b0001);

        // Load x7 in EX, ID reads rs2=x7: one stall, then stage 2
        step(); ex_set(7, 1); id_set(0, 7, 2'b10);
        @(negedge clk); check("load_stall", int'(stall), 1);
        step(); ex_off();
        @(negedge clk); check("load_stall_done", int'(stall), 0);
        check("load_bubble_sel", int'(fwd_sel), 0);
        step(); idle();
        @(negedge clk); check("load_sel", int'(fwd_sel), 4'b1000);
        check("load_count", int'(stall_count), 1);

        // x3: load in stage 1 is shadowed by the ALU in EX
        step(); ex_set(3, 1);
        step(); ex_set(3, 0); id_set(3, 0, 2'b01);
        @(negedge clk); check("shadow_stall", int'(stall), 0);
        step(); idle();
        @(negedge clk); check("shadow_sel", int'(fwd_sel), 4'b0001);

        // x0 never forwarded; unused operand never forwarded
        step(); ex_set(0, 0); id_set(0, 0, 2'b11);
        @(negedge clk); check("x0_stall", int'(stall), 0);
        step(); ex_set(5, 0); id_set(5, 5, 2'b00);
        @(negedge clk); check("x0_sel", int'(fwd_sel), 0);
        step(); idle();
        @(negedge clk); check("unused_sel", int'(fwd_sel), 0);

        // Producer in stage 1 -> sel 2; producer in stage 2 (retiring) -> regfile
        step(); ex_set(6, 0);
        step(); ex_off(); id_set(0, 6, 2'b10);
        step(); idle();
        @(negedge clk); check("stage1_sel", int'(fwd_sel), 4'b1000);
        step(); ex_set(8, 1);
        step(); ex_off();
        step(); id_set(8, 0, 2'b01);
        @(negedge clk); check("retire_stall", int'(stall), 0);
        step(); idle();
        @(negedge clk); check("retire_sel", int'(fwd_sel), 0);

        // Flush beats the hazard
        step(); ex_set(9, 1); id_set(9, 0, 2'b01); flush = 1;
        @(negedge clk); check("flush_stall", int'(stall), 0);
        step(); idle();
        @(negedge clk); check("flush_sel", int'(fwd_sel), 0);
        check("flush_count", int'(stall_count), 1);

        // 20 stall cycles saturate a 4-bit counter
        step(); ex_set(9, 1); id_set(9, 0, 2'b01);
        repeat (20) @(posedge clk);
        @(negedge clk); check("sat_count", int'(stall_count), 15);
        check("sat_stall", int'(stall), 1);

        // Reset mid-stall
        #1 reset = 1; ex_off();
        step(); reset = 0;
        @(negedge clk);
        check("rst_stall", int'(stall), 0);
        check("rst_sel", int'(fwd_sel), 0);
        check("rst_count", int'(stall_count), 0);
        check("rst_err", int'(hazard_err), 0);
        step(); idle(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
